// File: rtl/fetch_pkg.sv
// Purpose : shared widths, NOP encoding and the prefetch entry payload for the
//           instruction fetch front-end.
// Contents: INSTR_W / PC_W / FIFO_DEPTH defaults, NOP_INSTR, fetch_entry_t.
package fetch_pkg;

    localparam int unsigned INSTR_W    = 24;
    localparam int unsigned PC_W       = 16;
    localparam int unsigned FIFO_DEPTH = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    // One prefetched instruction tagged with the PC it was fetched from.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Purpose : instruction-memory read bus between the fetch unit and the
//           synchronous instruction memory.
// Signals : imemRdEn  - read strobe (fetch -> memory)
//           imemAddr  - word address (fetch -> memory)
//           imemData  - read data, valid the cycle after imemRdEn (memory -> fetch)
interface fetch_prefetch_unit_if
    import fetch_pkg::*;
#(
    parameter int unsigned pcSize          = PC_W,
    parameter int unsigned instructionSize = INSTR_W
) ();

    logic                       imemRdEn;
    logic [pcSize-1:0]          imemAddr;
    logic [instructionSize-1:0] imemData;

    modport master (output imemRdEn, output imemAddr, input imemData);
    modport slave  (input imemRdEn, input imemAddr, output imemData);

endinterface

// File: rtl/fetch_fifo.sv
// Purpose : synchronous prefetch FIFO of fetch_entry_t; flush beats push/pop.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           flush_i         - empty the FIFO this cycle
//           push_i, data_i  - write one entry
//           pop_i           - drop the head entry
//           head_o          - current head entry (combinational)
//           count_o         - registered occupancy
//           empty_o, full_o - occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 data_i,
    input  logic                         pop_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && !empty_o;

    // Pointer / occupancy next state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Purpose : instruction fetch front-end. Holds the fetch PC, issues one
//           instruction-memory read per cycle into a prefetch FIFO and presents
//           the FIFO head to decode; a redirect flushes and restarts the stream.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           redirectEn/Pc       - PC write from the memory stage
//           stall               - decode cannot accept this cycle
//           imem (master)       - imemRdEn / imemAddr / imemData read bus
//           instrOut, instrPc   - head instruction and its PC (zero when invalid)
//           instrValid          - instrOut is a real instruction
//           fetchActive         - mirrors imemRdEn
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned instructionSize = INSTR_W,
    parameter int unsigned pcSize          = PC_W,
    parameter int unsigned fifoDepth       = FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirectEn,
    input  logic [pcSize-1:0]            redirectPc,
    input  logic                         stall,
    fetch_prefetch_unit_if.master        imem,
    output logic [instructionSize-1:0]   instrOut,
    output logic [pcSize-1:0]            instrPc,
    output logic                         instrValid,
    output logic                         fetchActive
);

    localparam int unsigned CNT_W = $clog2(fifoDepth) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [pcSize-1:0] fetch_pc_q, fetch_pc_d;
    logic [pcSize-1:0] issued_pc_q, issued_pc_d;
    logic              inflight_q, inflight_d;
    logic              squash_q, squash_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty, fifo_full;
    fetch_entry_t      fifo_head;
    fetch_entry_t      push_entry;
    logic [OCC_W-1:0]  occupancy_c;
    logic              issue_c, push_c, pop_c;

    // The in-flight read reserves a slot; a same-cycle pop is deliberately not credited.
    assign occupancy_c = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    assign issue_c     = !rst && !redirectEn && (occupancy_c < OCC_W'(fifoDepth));

    assign push_c     = inflight_q && !squash_q && !redirectEn;
    assign push_entry = '{pc: issued_pc_q, instr: imem.imemData};

    assign instrValid = !fifo_empty && !redirectEn;
    assign pop_c      = instrValid && !stall;
    assign instrOut   = instrValid ? fifo_head.instr : NOP_INSTR;
    assign instrPc    = instrValid ? fifo_head.pc : '0;

    assign imem.imemRdEn = issue_c;
    assign imem.imemAddr = fetch_pc_q;
    assign fetchActive   = issue_c;

    // PC / in-flight tracking; redirect overrides issue.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = 1'b0;
        squash_d    = 1'b0;
        if (redirectEn) begin
            fetch_pc_d = redirectPc;
            squash_d   = inflight_q;
        end else if (issue_c) begin
            fetch_pc_d  = fetch_pc_q + pcSize'(1);
            issued_pc_d = fetch_pc_q;
            inflight_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= '0;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
            squash_q    <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            squash_q    <= squash_d;
        end
    end

    fetch_fifo #(.DEPTH(fifoDepth)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirectEn),
        .push_i  (push_c),
        .data_i  (push_entry),
        .pop_i   (pop_c),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // The issue throttle must make an overflowing push impossible.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(push_c && fifo_full));
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Instruction fetch front-end between the synchronous instruction memory and the fetch→decode pipe register. It holds the fetch PC and issues one read per cycle into a small prefetch FIFO. It presents one instruction per cycle to decode, with a stall input from decode. It takes the branch/PC-write redirect from the memory stage (PCWrEn_Mem, writeBackData_Mem[0]), flushes on redirect, and squashes the in-flight read.

Parameters:
instructionSize, 24, instruction word width
pcSize, 16, PC / instruction address width (word addressed, +1 per instruction)
fifoDepth, 4, prefetch entries (power of 2, ≥2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
redirectEn  in  1  PC write from memory stage
redirectPc  in  pcSize  new PC
stall  in  1  decode cannot accept this cycle
imemRdEn  out  1  read strobe to instruction memory
imemAddr  out  pcSize  read address
imemData  in  instructionSize  read data, valid the cycle after imemRdEn
instrOut  out  instructionSize  head instruction (NOP = all zeros when invalid)
instrPc  out  pcSize  PC of instrOut
instrValid  out  1  instrOut is a real instruction
fetchActive  out  1  equals imemRdEn

Behaviour:
- Interface fixed: single clock clk; rst is synchronous, active-high.
- Reset: fetchPc=0, FIFO empty, inflight=0, squash=0. All outputs 0 in the cycle after the rst edge: imemRdEn=0, imemAddr=0, instrOut=0, instrPc=0, instrValid=0.
- Issue: imemRdEn = !rst && !redirectEn && (count + inflight < fifoDepth). count is the registered occupancy; pop is not credited.
- imemAddr = fetchPc always. On issue, fetchPc <= fetchPc+1, wrapping mod 2^pcSize (0xFFFF→0x0000). inflight <= 1 and issuedPc <= fetchPc.
- Response: when inflight=1 and squash=0, push {issuedPc, imemData} into the FIFO at the end of that cycle. inflight clears unless a new issue occurs.
- No bypass. The first instruction after reset release has instrValid=1 in the third cycle: cycle0 issue, cycle1 data, cycle2 output.
- Output: instrOut/instrPc come combinationally from the FIFO head. instrValid = !empty && !redirectEn. When not valid, instrOut=0 and instrPc=0.
- Pop: instrValid && !stall. Push and pop in the same cycle leave count unchanged. The issue rule guarantees no overflow; push when full is a design error (assertion).
- Redirect (priority over stall, issue, push, pop):
  - FIFO flushed (count=0), fetchPc <= redirectPc, no issue that cycle.
  - A read in flight is squashed: squash <= 1 and its data is dropped next cycle.
  - The next cycle issues redirectPc. First valid output from the new stream comes 2 cycles after the issue.
- Redirect in consecutive cycles: the last one wins.
- Redirect with rst: rst wins, fetchPc=0.
- stall with empty FIFO: no effect.
- Stall held: FIFO fills to fifoDepth, then imemRdEn stays 0 until a pop. No instruction is lost or duplicated.
- Sustained throughput with stall=0 is 1 instruction/cycle.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR constant (all zeros)
  - fetch_entry_t struct {pc, instr}
  - default widths
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty/full.
  - Flush has priority over push/pop.
  - Pointers wrap mod fifoDepth.
- Top contains the PC, issue/inflight/squash logic and the output mux.

Test Plan:
1. Sequential fetch: imem[a]=0x100+a, release rst, stall=0 → imemAddr 0,1,2,… each cycle. instrValid first high in cycle 2 with instrPc=0, instrOut=0x000100, then one instruction per cycle in order.
2. Backpressure: stall=1 for 8 cycles after first valid → count saturates at 4 and imemRdEn=0 while full. On release, instrPc continues contiguously (0,1,2,3,4,…) with no gaps or duplicates.
3. Redirect with read in flight: redirectEn=1, redirectPc=0x0040 in a cycle following an issue → instrValid=0 that cycle and the next 2. The next valid has instrPc=0x0040, instrOut=0x000140. The squashed data never appears.
4. Redirect while full and stalled: FIFO full, stall=1, redirectEn=1 to 0x0010 → FIFO empties and stall is ignored. The next valid is pc 0x0010.
5. Wrap: redirect to 0xFFFE → outputs pcs 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order.
6. Mid-stream reset: assert rst for 1 cycle during steady fetch → next cycle all outputs 0. After release, fetch restarts at pc 0 with first valid in cycle 2.
